dtc_vote_accum: RTL and testbench

DTC_VOTE_ACCUM -- requirements
Module: dtc_vote_accum

---
 rtl/dtc_vote_accum.sv | 96 +++++++++
 tb/tb_dtc_vote_accum.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_vote_accum.sv
// Majority-vote accumulator for decision-tree class predictions.
// Counts per-class votes over a window of WINDOW samples (or until flush) and emits the winner.
module dtc_vote_accum #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       in_class,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [1:0]       out_class,
    output logic [CNT_W-1:0] out_votes,
    output logic [CNT_W-1:0] out_samples,
    input  logic             out_ready
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] EMIT  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt [4];
    logic [CNT_W-1:0] cnt_nxt [4];
    logic [CNT_W-1:0] nsamp;
    logic [CNT_W-1:0] nsamp_nxt;
    logic             accept;
    logic             close;
    logic [1:0]       win_class;
    logic [CNT_W-1:0] win_votes;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == EMIT);
    assign accept    = in_valid && in_ready;

    // Post-update counts feed both the window-close decision and the registered result.
    always_comb begin
        nsamp_nxt = nsamp + CNT_W'(accept);
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = cnt[i] + CNT_W'(accept && (in_class == 2'(i)));
        end
        win_class = 2'd0;
        win_votes = cnt_nxt[0];
        // Strict greater-than keeps the lowest index on ties.
        for (int i = 1; i < 4; i++) begin
            if (cnt_nxt[i] > win_votes) begin
                win_class = 2'(i);
                win_votes = cnt_nxt[i];
            end
        end
        close = (state == ACCUM) &&
                ((accept && (nsamp_nxt == CNT_W'(WINDOW))) ||
                 (flush && (nsamp_nxt != '0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            nsamp       <= '0;
            out_class   <= 2'd0;
            out_votes   <= '0;
            out_samples <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        nsamp <= nsamp_nxt;
                        for (int i = 0; i < 4; i++) begin
                            cnt[i] <= cnt_nxt[i];
                        end
                    end
                    if (close) begin
                        state       <= EMIT;
                        out_class   <= win_class;
                        out_votes   <= win_votes;
                        out_samples <= nsamp_nxt;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= ACCUM;
                        nsamp <= '0;
                        for (int i = 0; i < 4; i++) begin
                            cnt[i] <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Directed testbench for dtc_vote_accum with hand-computed vote results.
module tb_dtc_vote_accum;

    localparam int WINDOW = 16;
    localparam int CNT_W  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [1:0]       in_class = 2'd0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic             out_valid;
    logic [1:0]       out_class;
    logic [CNT_W-1:0] out_votes;
    logic [CNT_W-1:0] out_samples;
    logic             out_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    dtc_vote_accum #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_class   (in_class),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_class  (out_class),
        .out_votes  (out_votes),
        .out_samples(out_samples),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
        tests++; if (out_class !== 2'd0) begin fails++; $display("FAIL reset_out_class: got %0d expected 0", out_class); end
        tests++; if (out_votes !== 5'd0) begin fails++; $display("FAIL reset_out_votes: got %0d expected 0", out_votes); end
        tests++; if (out_samples !== 5'd0) begin fails++; $display("FAIL reset_out_samples: got %0d expected 0", out_samples); end
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0d expected 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < WINDOW; i++) begin
            in_valid = 1'b1; in_class = 2'd2;
            step();
        end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_out_valid: got %0d expected 1", out_valid); end
        tests++; if (out_class !== 2'd2) begin fails++; $display("FAIL b2b_out_class: got %0d expected 2", out_class); end
        tests++; if (out_votes !== 5'd16) begin fails++; $display("FAIL b2b_out_votes: got %0d expected 16", out_votes); end
        tests++; if (out_samples !== 5'd16) begin fails++; $display("FAIL b2b_out_samples: got %0d expected 16", out_samples); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_in_ready_emit: got %0d expected 0", in_ready); end
        // Handshake edge: the held sample must not be taken here.
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_out_valid_after: got %0d expected 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready_after: got %0d expected 1", in_ready); end
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (out_samples !== 5'd1) begin fails++; $display("FAIL b2b_next_samples: got %0d expected 1", out_samples); end
        tests++; if (out_class !== 2'd2) begin fails++; $display("FAIL b2b_next_class: got %0d expected 2", out_class); end
        step();
    endtask

    task automatic test_tie();
        out_ready = 1'b1;
        for (int i = 0; i < WINDOW; i++) begin
            in_valid = 1'b1; in_class = 2'(i % 4);
            step();
        end
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL tie_out_valid: got %0d expected 1", out_valid); end
        tests++; if (out_class !== 2'd0) begin fails++; $display("FAIL tie_out_class: got %0d expected 0", out_class); end
        tests++; if (out_votes !== 5'd4) begin fails++; $display("FAIL tie_out_votes: got %0d expected 4", out_votes); end
        tests++; if (out_samples !== 5'd16) begin fails++; $display("FAIL tie_out_samples: got %0d expected 16", out_samples); end
        step();
        // Reverse order: a greater-or-equal compare would pick class 3 here.
        for (int i = 0; i < WINDOW; i++) begin
            in_valid = 1'b1; in_class = 2'(3 - (i % 4));
            step();
        end
        in_valid = 1'b0;
        tests++; if (out_class !== 2'd0) begin fails++; $display("FAIL tie_rev_out_class: got %0d expected 0", out_class); end
        tests++; if (out_votes !== 5'd4) begin fails++; $display("FAIL tie_rev_out_votes: got %0d expected 4", out_votes); end
        step();
    endtask

    task automatic test_flush();
        logic [1:0] seq [5];
        seq = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd3};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_class = seq[i];
            step();
        end
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_premature_valid: got %0d expected 0", out_valid); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL flush_out_valid: got %0d expected 1", out_valid); end
        tests++; if (out_class !== 2'd3) begin fails++; $display("FAIL flush_out_class: got %0d expected 3", out_class); end
        tests++; if (out_votes !== 5'd3) begin fails++; $display("FAIL flush_out_votes: got %0d expected 3", out_votes); end
        tests++; if (out_samples !== 5'd5) begin fails++; $display("FAIL flush_out_samples: got %0d expected 5", out_samples); end
        step();
    endtask

    task automatic test_empty_flush();
        out_ready = 1'b1;
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL empty_flush_valid: got %0d expected 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL empty_flush_in_ready: got %0d expected 1", in_ready); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL empty_flush_valid_late: got %0d expected 0", out_valid); end
    endtask

    task automatic test_flush_with_sample();
        out_ready = 1'b1;
        in_valid = 1'b1; in_class = 2'd1;
        step();
        in_class = 2'd1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fws_out_valid: got %0d expected 1", out_valid); end
        tests++; if (out_samples !== 5'd2) begin fails++; $display("FAIL fws_out_samples: got %0d expected 2", out_samples); end
        tests++; if (out_votes !== 5'd2) begin fails++; $display("FAIL fws_out_votes: got %0d expected 2", out_votes); end
        tests++; if (out_class !== 2'd1) begin fails++; $display("FAIL fws_out_class: got %0d expected 1", out_class); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < WINDOW; i++) begin
            in_valid = 1'b1; in_class = (i == WINDOW - 1) ? 2'd3 : 2'd1;
            step();
        end
        // Keep offering class 0 samples; none may be counted while stalled.
        in_class = 2'd0;
        for (int i = 0; i < 10; i++) begin
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid[%0d]: got %0d expected 1", i, out_valid); end
            tests++; if (out_class !== 2'd1) begin fails++; $display("FAIL bp_out_class[%0d]: got %0d expected 1", i, out_class); end
            tests++; if (out_votes !== 5'd15) begin fails++; $display("FAIL bp_out_votes[%0d]: got %0d expected 15", i, out_votes); end
            tests++; if (out_samples !== 5'd16) begin fails++; $display("FAIL bp_out_samples[%0d]: got %0d expected 16", i, out_samples); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %0d expected 0", i, in_ready); end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %0d expected 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_out_valid: got %0d expected 0", out_valid); end
        in_valid = 1'b1; in_class = 2'd2; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        tests++; if (out_samples !== 5'd1) begin fails++; $display("FAIL bp_cleared_samples: got %0d expected 1", out_samples); end
        tests++; if (out_votes !== 5'd1) begin fails++; $display("FAIL bp_cleared_votes: got %0d expected 1", out_votes); end
        tests++; if (out_class !== 2'd2) begin fails++; $display("FAIL bp_cleared_class: got %0d expected 2", out_class); end
        step();
    endtask

    task automatic test_reset_emit();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_class = 2'd3;
            step();
        end
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_emit_pre_valid: got %0d expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_emit_async_valid: got %0d expected 0", out_valid); end
        tests++; if (out_samples !== 5'd0) begin fails++; $display("FAIL rst_emit_async_samples: got %0d expected 0", out_samples); end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_class = 2'd1;
        step();
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (out_samples !== 5'd2) begin fails++; $display("FAIL rst_emit_next_samples: got %0d expected 2", out_samples); end
        tests++; if (out_class !== 2'd1) begin fails++; $display("FAIL rst_emit_next_class: got %0d expected 1", out_class); end
        tests++; if (out_votes !== 5'd2) begin fails++; $display("FAIL rst_emit_next_votes: got %0d expected 2", out_votes); end
        step();
    endtask

    initial begin
        #2;
        test_reset();
        test_back_to_back();
        test_tie();
        test_flush();
        test_empty_flush();
        test_flush_with_sample();
        test_backpressure();
        test_reset_emit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
